ahb_sram_ctrl: RTL and testbench

//  AHB-lite subordinate that drives the sram_1024x32 memory: the requester side of its addr/data/wren/q port.

---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_sram_lane_merge.sv | 37 +++
 rtl/sram_1024x32.sv | 25 ++
 rtl/ahb_sram_ctrl.sv | 122 ++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite constants and the subordinate data-phase state encoding.
// No logic, no latency.
// No flow control of its own.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // IDLE: no data phase, DATA: legal transfer, ERR1/ERR2: two-cycle error response
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

endpackage

// File: rtl/ahb_sram_lane_merge.sv
// Byte-lane mask from HSIZE/HADDR[1:0], and write-word merge of new and old lanes.
// Combinational, zero latency.
// No flow control; the caller decides when the merged word is used.
module ahb_sram_lane_merge
   import ahb_pkg::*;
(
   input  logic [1:0]  i_hsize,
   input  logic [1:0]  i_addr,
   output logic [3:0]  o_mask,
   input  logic [3:0]  i_dph_mask,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [31:0] w_bitmask;

   // Address-phase lane mask, little-endian: byte 0 lives in bits [7:0]
   always_comb begin
      o_mask = 4'hF;
      case (i_hsize)
         HSIZE_BYTE[1:0]: o_mask = 4'b0001 << i_addr;
         HSIZE_HALF[1:0]: o_mask = i_addr[1] ? 4'b1100 : 4'b0011;
         default:         o_mask = 4'hF;
      endcase
   end

   // Expand the registered lane mask to bits and keep the old word's unselected lanes
   always_comb begin
      w_bitmask = '0;
      for (int b = 0; b < 4; b++) begin
         w_bitmask[8*b +: 8] = {8{i_dph_mask[b]}};
      end
      o_data = (i_wdata & w_bitmask) | (i_rdata & ~w_bitmask);
   end

endmodule

// File: rtl/sram_1024x32.sv
// Single-port 1024x32 SRAM with registered address and combinational read of the registered word.
// Read word valid the cycle after the address is presented; writes land at the registered address.
// No flow control; accepts an address and optional write every edge.
module sram_1024x32 (
   input  logic        clk,
   input  logic [9:0]  addr,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q
);

   logic [31:0] r_mem [0:1023];
   logic [9:0]  r_addr;

   // Write to the previously registered address, then capture the new one
   always_ff @(posedge clk) begin
      if (wren) begin
         r_mem[r_addr] <= data;
      end
      r_addr <= addr;
   end

   assign q = r_mem[r_addr];

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-lite subordinate in front of one sram_1024x32: zero-wait reads/writes, subword writes merged in-cycle.
// Read data one cycle after the address phase; writes land at the end of the data phase.
// HREADYOUT only drops in the first cycle of the two-cycle ERROR response.
module ahb_sram_ctrl
   import ahb_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL,
   input  logic [31:0]   HADDR,
   input  logic [1:0]    HTRANS,
   input  logic          HWRITE,
   input  logic [2:0]    HSIZE,
   input  logic [DW-1:0] HWDATA,
   input  logic          HREADY,
   output logic          HREADYOUT,
   output logic          HRESP,
   output logic [DW-1:0] HRDATA,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_data,
   output logic          sram_wren,
   input  logic [DW-1:0] sram_q
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_dph_addr;
   logic          r_dph_write;
   logic [3:0]    r_dph_mask;
   logic          w_accept;
   logic          w_legal;
   logic [3:0]    w_mask;
   logic          w_unused_bits;

   assign w_accept = HSEL & HREADY & HTRANS[1];

   // Upper address bits alias by design; HTRANS[0] only distinguishes SEQ from NONSEQ
   assign w_unused_bits = ^{HTRANS[0], HADDR[31:AW+2]};

   // Reject oversized transfers and misaligned word/halfword accesses
   always_comb begin
      w_legal = 1'b1;
      if (HSIZE > HSIZE_WORD) begin
         w_legal = 1'b0;
      end else if (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00) begin
         w_legal = 1'b0;
      end else if (HSIZE == HSIZE_HALF && HADDR[0]) begin
         w_legal = 1'b0;
      end
   end

   // Hold the data-phase address while the bus stalls so the SRAM's registered address stays put
   assign sram_addr = HREADY ? HADDR[AW+1:2] : r_dph_addr;

   ahb_sram_lane_merge u_lane_merge (
      .i_hsize    (HSIZE[1:0]),
      .i_addr     (HADDR[1:0]),
      .o_mask     (w_mask),
      .i_dph_mask (r_dph_mask),
      .i_wdata    (HWDATA),
      .i_rdata    (sram_q),
      .o_data     (sram_data)
   );

   // State register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Data-phase context captured on every accepted transfer
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dph_addr  <= '0;
         r_dph_write <= 1'b0;
         r_dph_mask  <= 4'h0;
      end else if (w_accept) begin
         r_dph_addr  <= HADDR[AW+1:2];
         r_dph_write <= HWRITE;
         r_dph_mask  <= w_mask;
      end
   end

   // Next state and data-phase outputs; ERR1 never sees an accept because HREADY is low there
   always_comb begin
      w_state_nxt = ST_IDLE;
      HREADYOUT   = 1'b1;
      HRESP       = HRESP_OKAY;
      sram_wren   = 1'b0;
      HRDATA      = '0;
      case (r_state)
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
         end
         ST_ERR2: begin
            HRESP = HRESP_ERROR;
         end
         ST_DATA: begin
            if (r_dph_write) begin
               sram_wren = 1'b1;
            end else begin
               HRDATA = sram_q;
            end
         end
         default: begin
         end
      endcase
      if (r_state == ST_ERR1) begin
         w_state_nxt = ST_ERR2;
      end else if (w_accept) begin
         w_state_nxt = w_legal ? ST_DATA : ST_ERR1;
      end
   end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
module tb_ahb_sram_ctrl;
   import ahb_pkg::*;

   localparam int K_NONE = 0;
   localparam int K_WR   = 1;
   localparam int K_RD   = 2;
   localparam int K_ERR1 = 3;
   localparam int K_ERR2 = 4;

   logic        HCLK;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic [9:0]  sram_addr;
   logic [31:0] sram_data;
   logic        sram_wren;
   logic [31:0] sram_q;

   int n_checks;
   int n_errors;

   // reference model: word array plus a description of the transfer in data phase
   logic [31:0] mem_model [0:1023];
   int          dp_kind;
   logic [9:0]  dp_word;
   int          dp_off;
   int          dp_nb;
   logic [31:0] dp_wdata;
   logic [31:0] last_rd;
   logic [31:0] rd_log [$];

   assign HREADY = HREADYOUT;

   ahb_sram_ctrl #(.AW(10), .DW(32)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .sram_addr (sram_addr),
      .sram_data (sram_data),
      .sram_wren (sram_wren),
      .sram_q    (sram_q)
   );

   sram_1024x32 u_sram (
      .clk  (HCLK),
      .addr (sram_addr),
      .data (sram_data),
      .wren (sram_wren),
      .q    (sram_q)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // writing nb bytes starting at lane off replaces exactly those lanes
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input int off, input int nb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (b >= off && b < off + nb) r[8*b +: 8] = nw[8*b +: 8];
      end
      return r;
   endfunction

   function automatic bit is_legal(input logic [2:0] size, input logic [1:0] off);
      int nb;
      if (size > 3'd2) return 1'b0;
      nb = 1 << size;
      return (int'(off) % nb) == 0;
   endfunction

   task automatic check_dphase();
      logic [2:0] ctl;
      ctl = {HREADYOUT, HRESP, sram_wren};
      case (dp_kind)
         K_WR: begin
            check("wr_ctl", 32'(ctl), 32'b101);
            check("wr_rdata", HRDATA, 32'h0);
            check("wr_sram_data", sram_data, merge(mem_model[dp_word], dp_wdata, dp_off, dp_nb));
         end
         K_RD: begin
            check("rd_ctl", 32'(ctl), 32'b100);
            check("rd_data", HRDATA, mem_model[dp_word]);
            last_rd = HRDATA;
            rd_log.push_back(HRDATA);
         end
         K_ERR1: begin
            check("err1_ctl", 32'(ctl), 32'b010);
            check("err1_rdata", HRDATA, 32'h0);
         end
         K_ERR2: begin
            check("err2_ctl", 32'(ctl), 32'b110);
            check("err2_rdata", HRDATA, 32'h0);
         end
         default: begin
            check("idle_ctl", 32'(ctl), 32'b100);
            check("idle_rdata", HRDATA, 32'h0);
         end
      endcase
   endtask

   // one address phase (held through ERR1 stalls) plus the data phase of the previous transfer
   task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdat);
      bit          taken;
      int          nx_kind;
      logic [31:0] nx_wdata;
      taken = 1'b0;
      while (!taken) begin
         HSEL   = sel;
         HTRANS = trans;
         HWRITE = wr;
         HSIZE  = size;
         HADDR  = addr;
         HWDATA = dp_wdata;
         @(negedge HCLK);
         check_dphase();
         nx_wdata = 32'h0;
         if (dp_kind == K_ERR1) begin
            nx_kind = K_ERR2;
         end else begin
            taken = 1'b1;
            if (sel && trans[1]) begin
               if (!is_legal(size, addr[1:0])) nx_kind = K_ERR1;
               else if (wr) begin
                  nx_kind  = K_WR;
                  nx_wdata = wdat;
               end else nx_kind = K_RD;
            end else begin
               nx_kind = K_NONE;
            end
         end
         @(posedge HCLK);
         if (dp_kind == K_WR) mem_model[dp_word] = merge(mem_model[dp_word], dp_wdata, dp_off, dp_nb);
         if (taken) begin
            dp_word = addr[11:2];
            dp_off  = int'(addr[1:0]);
            dp_nb   = (size <= 3'd2) ? (1 << size) : 4;
         end
         dp_kind  = nx_kind;
         dp_wdata = nx_wdata;
         #1;
      end
   endtask

   task automatic idle_step();
      step(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] saved;
      logic [31:0] r;
      logic [31:0] a;
      logic [2:0]  sz;
      n_checks = 0;
      n_errors = 0;
      dp_kind  = K_NONE;
      dp_word  = '0;
      dp_off   = 0;
      dp_nb    = 4;
      dp_wdata = 32'h0;
      last_rd  = 32'h0;
      HRESETn  = 1'b0;
      HSEL     = 1'b0;
      HTRANS   = HTRANS_IDLE;
      HWRITE   = 1'b0;
      HSIZE    = HSIZE_WORD;
      HADDR    = 32'h0;
      HWDATA   = 32'h0;
      repeat (3) @(posedge HCLK);
      #1;
      check("reset_ctl", 32'({HREADYOUT, HRESP, sram_wren}), 32'b100);
      check("reset_rdata", HRDATA, 32'h0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;

      // give every word in the working window a known value
      for (int w = 0; w < 32; w++) step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(w * 4), $urandom());
      idle_step();

      // word write then read
      step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
      step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
      idle_step();
      check("t1_word_rd", last_rd, 32'hDEADBEEF);

      // byte and halfword merges
      step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h11223344);
      step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h21, 32'h0000AA00);
      step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
      idle_step();
      check("t2_byte_rd", last_rd, 32'h1122AA44);
      step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h22, 32'hBEEF0000);
      step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
      idle_step();
      check("t2_half_rd", last_rd, 32'hBEEFAA44);

      // pipelined write/read pairs, no wait states
      rd_log.delete();
      step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'h5);
      step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
      step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h44, 32'h6);
      step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h44, 32'h0);
      idle_step();
      check("t3_nreads", 32'(rd_log.size()), 32'd2);
      check("t3_rd0", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFFFFFF, 32'h5);
      check("t3_rd1", (rd_log.size() > 1) ? rd_log[1] : 32'hFFFFFFFF, 32'h6);

      // misaligned word write -> ERROR, memory untouched
      saved = mem_model[0];
      step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h02, 32'h12345678);
      idle_step();
      step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'h0);
      idle_step();
      check("t4_word0_kept", last_rd, saved);

      // oversize read -> ERROR, transfer issued during ERR2 is honoured
      step(1'b1, HTRANS_NONSEQ, 1'b0, 3'd3, 32'h08, 32'h0);
      step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
      idle_step();
      check("t5_after_err", last_rd, 32'hDEADBEEF);

      // reset asserted in the middle of a write data phase
      saved = mem_model[24];
      step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h60, 32'hCAFEF00D);
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
      HWDATA = 32'hCAFEF00D;
      #1;
      check("t6_wren_before", 32'(sram_wren), 32'd1);
      HRESETn = 1'b0;
      #1;
      check("t6_rst_ctl", 32'({HREADYOUT, HRESP, sram_wren}), 32'b100);
      check("t6_rst_rdata", HRDATA, 32'h0);
      @(posedge HCLK);
      #1;
      check("t6_rst_ctl_held", 32'({HREADYOUT, HRESP, sram_wren}), 32'b100);
      check("t6_rst_rdata_held", HRDATA, 32'h0);
      @(negedge HCLK);
      HRESETn  = 1'b1;
      dp_kind  = K_NONE;
      dp_wdata = 32'h0;
      @(posedge HCLK);
      #1;
      step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h60, 32'h0);
      idle_step();
      check("t6_word_kept", last_rd, saved);

      // BUSY and deselected cycles never write
      step(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hFFFFFFFF);
      step(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h10, 32'hFFFFFFFF);
      step(1'b0, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 32'h11, 32'hFFFFFFFF);
      step(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h10, 32'hFFFFFFFF);
      step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
      idle_step();
      check("t7_no_write", last_rd, 32'hDEADBEEF);

      // random traffic over the window, upper address bits random to exercise aliasing
      for (int i = 0; i < 500; i++) begin
         r  = $urandom();
         a  = {r[31:12], 5'b0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
         sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
         step(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              sz, a, $urandom());
      end
      idle_step();
      idle_step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
